// File: rtl/mat_mac_engine.sv
`timescale 1ns/1ps
// Matrix multiply-accumulate engine: C = A * B^T, streamed from two read SRAMs into a result SRAM.
// Define MAT_MAC_SATURATE_EN to clamp results to DATA_W; otherwise results are truncated.
module mat_mac_engine #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int ACC_W       = 64,
    parameter int SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_W-1:0]     a_base,
    input  logic [ADDR_W-1:0]     b_base,
    input  logic [ADDR_W-1:0]     c_base,
    output logic [ADDR_W-1:0]     a_rd_addr,
    output logic [ADDR_W-1:0]     b_rd_addr,
    input  logic [DATA_W-1:0]     a_rd_data,
    input  logic [DATA_W-1:0]     b_rd_data,
    output logic                  c_wr_en,
    output logic [ADDR_W-1:0]     c_wr_addr,
    output logic [DATA_W-1:0]     c_wr_data,
    output logic [DATA_W/2-1:0]   m_dim,
    output logic [DATA_W/2-1:0]   n_dim,
    output logic [DATA_W/2-1:0]   k_dim
);
    localparam int HW = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] DIM_RD  = 4'd1;
    localparam logic [3:0] DIM_CHK = 4'd2;
    localparam logic [3:0] PRIME   = 4'd3;
    localparam logic [3:0] ACCUM   = 4'd4;
    localparam logic [3:0] DRAIN   = 4'd5;
    localparam logic [3:0] WRITE   = 4'd6;
    localparam logic [3:0] DONE    = 4'd7;
    localparam logic [3:0] ERR     = 4'd8;

    logic [3:0]        state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] a_rd_addr_q, a_rd_addr_d, b_rd_addr_q, b_rd_addr_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, b_row_q, b_row_d, b_base_q, b_base_d;
    logic [ADDR_W-1:0] c_ptr_q, c_ptr_d, c_wr_addr_q, c_wr_addr_d;
    logic              c_wr_en_q, c_wr_en_d;
    logic [DATA_W-1:0] c_wr_data_q, c_wr_data_d;
    logic [HW-1:0]     m_dim_q, m_dim_d, n_dim_q, n_dim_d, k_dim_q, k_dim_d;
    logic [HW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [DATA_W-1:0] narrowed;

    always_comb begin
        if (SIGNED_MODE != 0) begin
            prod     = PW'($signed(a_rd_data)) * PW'($signed(b_rd_data));
            prod_ext = ACC_W'($signed(prod));
        end else begin
            prod     = PW'(a_rd_data) * PW'(b_rd_data);
            prod_ext = ACC_W'(prod);
        end
    end

    always_comb begin
        narrowed = acc_q[DATA_W-1:0];
`ifdef MAT_MAC_SATURATE_EN
        // In range only when every bit above the result's sign bit matches it.
        if (SIGNED_MODE != 0) begin
            if (!((&acc_q[ACC_W-1:DATA_W-1]) || !(|acc_q[ACC_W-1:DATA_W-1])))
                narrowed = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                          : {1'b0, {(DATA_W-1){1'b1}}};
        end else if (|acc_q[ACC_W-1:DATA_W]) begin
            narrowed = '1;
        end
`endif
    end

    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        a_rd_addr_d = a_rd_addr_q;
        b_rd_addr_d = b_rd_addr_q;
        a_row_d     = a_row_q;
        b_row_d     = b_row_q;
        b_base_d    = b_base_q;
        c_ptr_d     = c_ptr_q;
        c_wr_addr_d = c_wr_addr_q;
        c_wr_data_d = c_wr_data_q;
        m_dim_d     = m_dim_q;
        n_dim_d     = n_dim_q;
        k_dim_d     = k_dim_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DIM_RD;
                    err_d       = 1'b0;
                    a_rd_addr_d = a_base;
                    b_rd_addr_d = b_base;
                    a_row_d     = a_base + ADDR_W'(1);
                    b_row_d     = b_base + ADDR_W'(1);
                    b_base_d    = b_base;
                    c_ptr_d     = c_base;
                    i_d         = '0;
                    j_d         = '0;
                end
            end
            DIM_RD: state_d = DIM_CHK;
            DIM_CHK: begin
                m_dim_d = a_rd_data[DATA_W-1:HW];
                n_dim_d = b_rd_data[DATA_W-1:HW];
                k_dim_d = a_rd_data[HW-1:0];
                if (a_rd_data[HW-1:0] != b_rd_data[HW-1:0] || a_rd_data[DATA_W-1:HW] == '0 ||
                    b_rd_data[DATA_W-1:HW] == '0 || a_rd_data[HW-1:0] == '0) begin
                    state_d = ERR;
                end else begin
                    state_d     = PRIME;
                    a_rd_addr_d = a_row_q;
                    b_rd_addr_d = b_row_q;
                end
            end
            PRIME: begin
                state_d     = ACCUM;
                k_d         = '0;
                a_rd_addr_d = a_rd_addr_q + ADDR_W'(1);
                b_rd_addr_d = b_rd_addr_q + ADDR_W'(1);
            end
            ACCUM: begin
                // Data for index k arrives this cycle; the first product replaces the old sum.
                acc_d       = (k_q == '0) ? prod_ext : acc_q + prod_ext;
                k_d         = k_q + HW'(1);
                a_rd_addr_d = a_rd_addr_q + ADDR_W'(1);
                b_rd_addr_d = b_rd_addr_q + ADDR_W'(1);
                if (k_q == k_dim_q - HW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                state_d     = WRITE;
                c_wr_addr_d = c_ptr_q;
                c_wr_data_d = narrowed;
                if (j_q == n_dim_q - HW'(1)) begin
                    j_d     = '0;
                    i_d     = i_q + HW'(1);
                    b_row_d = b_base_q + ADDR_W'(1);
                    a_row_d = a_row_q + ADDR_W'(k_dim_q);
                end else begin
                    j_d     = j_q + HW'(1);
                    b_row_d = b_row_q + ADDR_W'(k_dim_q);
                end
            end
            WRITE: begin
                c_ptr_d     = c_ptr_q + ADDR_W'(1);
                a_rd_addr_d = a_row_q;
                b_rd_addr_d = b_row_q;
                state_d     = (i_q == m_dim_q) ? DONE : PRIME;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) err_d = 1'b1;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE) || (state_d == ERR);
        c_wr_en_d = (state_d == WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            a_rd_addr_q <= '0;
            b_rd_addr_q <= '0;
            a_row_q     <= '0;
            b_row_q     <= '0;
            b_base_q    <= '0;
            c_ptr_q     <= '0;
            c_wr_en_q   <= 1'b0;
            c_wr_addr_q <= '0;
            c_wr_data_q <= '0;
            m_dim_q     <= '0;
            n_dim_q     <= '0;
            k_dim_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            a_rd_addr_q <= a_rd_addr_d;
            b_rd_addr_q <= b_rd_addr_d;
            a_row_q     <= a_row_d;
            b_row_q     <= b_row_d;
            b_base_q    <= b_base_d;
            c_ptr_q     <= c_ptr_d;
            c_wr_en_q   <= c_wr_en_d;
            c_wr_addr_q <= c_wr_addr_d;
            c_wr_data_q <= c_wr_data_d;
            m_dim_q     <= m_dim_d;
            n_dim_q     <= n_dim_d;
            k_dim_q     <= k_dim_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign a_rd_addr = a_rd_addr_q;
    assign b_rd_addr = b_rd_addr_q;
    assign c_wr_en   = c_wr_en_q;
    assign c_wr_addr = c_wr_addr_q;
    assign c_wr_data = c_wr_data_q;
    assign m_dim     = m_dim_q;
    assign n_dim     = n_dim_q;
    assign k_dim     = k_dim_q;
endmodule

// File: tb/tb_mat_mac_engine.sv
`timescale 1ns/1ps
// Self-checking bench for mat_mac_engine: SRAM models, a plain-arithmetic matrix model,
// directed corner jobs and randomized jobs.
module tb_mat_mac_engine;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [11:0] a_base = '0, b_base = '0, c_base = '0;
    logic [11:0] a_rd_addr, b_rd_addr, c_wr_addr;
    logic [31:0] a_rd_data, b_rd_data, c_wr_data;
    logic        c_wr_en;
    logic [15:0] m_dim, n_dim, k_dim;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] a_mem [4096];
    logic [31:0] b_mem [4096];
    logic [31:0] a_vals [64];
    logic [31:0] b_vals [64];
    wr_t         wr_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    mat_mac_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_rd_data <= a_mem[a_rd_addr];
        b_rd_data <= b_mem[b_rd_addr];
    end

    always @(posedge clk) begin
        if (reset_n && c_wr_en) wr_q.push_back('{c_wr_addr, c_wr_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] narrow(input longint s);
`ifdef MAT_MAC_SATURATE_EN
        if (s > SMAX) return 32'h7FFF_FFFF;
        if (s < SMIN) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'($signed(int'($urandom_range(0, 31)) - 16));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_wr_en"}, c_wr_en, 0);
        check({tag, "_addrs"}, {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
        check({tag, "_wr_data"}, c_wr_data, 0);
        check({tag, "_dims"}, {m_dim, n_dim, k_dim}, 0);
    endtask

    // Loads the job into the SRAM models, runs it and compares against the model.
    task automatic run_job(input string tag, input int m, input int n, input int ka, input int kb,
                           input logic [11:0] ab, input logic [11:0] bb, input logic [11:0] cb,
                           input bit poke);
        wr_t    exp_q [$];
        longint s;
        int     cyc;
        bit     bad;
        a_mem[ab] = {16'(m), 16'(ka)};
        b_mem[bb] = {16'(n), 16'(kb)};
        for (int idx = 0; idx < m * ka; idx++) a_mem[ab + 12'(1 + idx)] = a_vals[idx];
        for (int idx = 0; idx < n * kb; idx++) b_mem[bb + 12'(1 + idx)] = b_vals[idx];
        bad = (ka != kb) || (m == 0) || (n == 0) || (ka == 0);
        if (!bad) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    s = 0;
                    for (int k = 0; k < ka; k++)
                        s += longint'($signed(a_vals[i * ka + k])) * longint'($signed(b_vals[j * ka + k]));
                    exp_q.push_back('{cb + 12'(i * n + j), narrow(s)});
                end
            end
        end
        @(negedge clk);
        wr_q.delete();
        a_base = ab;
        b_base = bb;
        c_base = cb;
        start  = 1'b1;
        cyc    = 1;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (poke && cyc == 6) begin
                start  = 1'b1;
                a_base = ~ab;
                c_base = ~cb;
            end
        end while (!done && cyc < 1000);
        check({tag, "_latency"}, cyc, bad ? 4 : 4 + m * n * (ka + 3));
        check({tag, "_busy_at_done"}, busy, 1);
        check({tag, "_err"}, err, bad);
        if (!bad) check({tag, "_dims"}, {m_dim, n_dim, k_dim}, {16'(m), 16'(n), 16'(ka)});
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_err_sticky"}, err, bad);
        check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        for (int w = 0; w < exp_q.size() && w < wr_q.size(); w++) begin
            check($sformatf("%s_wr%0d_addr", tag, w), wr_q[w].addr, exp_q[w].addr);
            check($sformatf("%s_wr%0d_data", tag, w), wr_q[w].data, exp_q[w].data);
        end
    endtask

    initial begin
        int m, n, k;
        for (int i = 0; i < 4096; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        a_vals[0] = 32'd3;
        b_vals[0] = 32'd5;
        run_job("single", 1, 1, 1, 1, 12'h000, 12'h000, 12'h040, 1'b0);
        check("single_value", wr_q.size() > 0 ? wr_q[0].data : 32'hDEAD, 32'd15);

        a_vals[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_vals[0:3] = '{32'd1, 32'd0, 32'd0, 32'd1};
        run_job("ident", 2, 2, 2, 2, 12'h100, 12'h200, 12'h010, 1'b0);

        run_job("kmismatch", 1, 1, 3, 2, 12'h300, 12'h300, 12'h020, 1'b0);
        repeat (3) @(negedge clk);
        check("kmismatch_err_held", err, 1);

        a_vals[0:1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        b_vals[0:1] = '{32'd2, 32'd0};
        run_job("overflow", 1, 1, 2, 2, 12'h400, 12'h400, 12'h030, 1'b0);

        a_vals[0] = 32'hFFFF_FFFD;
        b_vals[0] = 32'd4;
        run_job("negative", 1, 1, 1, 1, 12'h500, 12'h500, 12'h031, 1'b0);
        check("negative_value", wr_q.size() > 0 ? wr_q[0].data : 32'hDEAD, 32'hFFFF_FFF4);

        for (int idx = 0; idx < 16; idx++) begin
            a_vals[idx] = rand_word();
            b_vals[idx] = rand_word();
        end
        run_job("wrap", 2, 3, 2, 2, 12'hFFE, 12'hFFC, 12'hFFD, 1'b0);

        // Abort a 4x4x4 job mid-accumulation, then confirm a clean restart.
        a_mem[12'h600] = {16'd4, 16'd4};
        b_mem[12'h600] = {16'd4, 16'd4};
        @(negedge clk);
        wr_q.delete();
        a_base = 12'h600;
        b_base = 12'h600;
        c_base = 12'h080;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_writes", wr_q.size(), 0);
        check("abort_idle", busy, 0);
        a_vals[0:3] = '{32'd7, 32'hFFFF_FFFE, 32'd5, 32'd9};
        b_vals[0:3] = '{32'd3, 32'd4, 32'hFFFF_FFF0, 32'd2};
        run_job("restart", 2, 2, 2, 2, 12'h700, 12'h710, 12'h090, 1'b0);

        for (int t = 0; t < 6; t++) begin
            m = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            k = $urandom_range(1, 4);
            for (int idx = 0; idx < m * k; idx++) a_vals[idx] = rand_word();
            for (int idx = 0; idx < n * k; idx++) b_vals[idx] = rand_word();
            run_job($sformatf("rand%0d", t), m, n, k, k, 12'($urandom), 12'($urandom),
                    12'($urandom), t == 2 || t == 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
